// File: rtl/jtdsp16_pkg.sv
// jtdsp16_pkg: shared program-control encodings, loop-entry layout and defaults.
package jtdsp16_pkg;
    localparam int DEF_IRQ_VEC = 1;

    typedef enum logic [2:0] {OP_SEQ, OP_JA, OP_PT, OP_RET, OP_IRET, OP_DO} flow_op_e;

    // Loop entry packs {head, end, left}: two addresses plus the repeat count.
    function automatic int loop_w(input int aw, input int cw);
        return 2 * aw + cw;
    endfunction
endpackage

// File: rtl/jtdsp16_lifo.sv
// jtdsp16_lifo: parametrised stack with optional circular overwrite and
// in-place update of the top entry.
module jtdsp16_lifo #(
    parameter int W   = 8,
    parameter int D   = 4,
    parameter bit OVW = 1'b1
) (
    input  logic                   rst,
    input  logic                   clk,
    input  logic                   cen,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   upd,
    input  logic [W-1:0]           din,
    input  logic [W-1:0]           upd_data,
    output logic [W-1:0]           dout,
    output logic [$clog2(D+1)-1:0] lvl,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = D > 1 ? $clog2(D) : 1;
    localparam int LW = $clog2(D + 1);

    logic [W-1:0]  mem [D];
    logic [PW-1:0] ptr, top, inc;
    logic          wr;

    always_comb begin
        top   = ptr == '0 ? PW'(D - 1) : ptr - 1'b1;
        inc   = ptr == PW'(D - 1) ? '0 : ptr + 1'b1;
        full  = lvl == LW'(D);
        empty = lvl == '0;
        dout  = mem[top];
        wr    = cen && push && (!full || OVW);
    end

    always_ff @(posedge clk) begin
        if (wr) mem[ptr] <= din;
        else if (cen && upd) mem[top] <= upd_data;
    end

    // A push into a full circular stack overwrites the oldest slot, so the level saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            lvl <= '0;
        end else if (wr) begin
            ptr <= inc;
            lvl <= full ? lvl : lvl + 1'b1;
        end else if (cen && pop && !empty) begin
            ptr <= top;
            lvl <= lvl - 1'b1;
        end
    end
endmodule

// File: rtl/jtdsp16_pcu.sv
// jtdsp16_pcu: program control unit - fetch address, jumps/calls with a return
// stack, interrupt entry/return and nested zero-overhead DO loops.
module jtdsp16_pcu import jtdsp16_pkg::*; #(
    parameter int AW      = 16,
    parameter int JW      = 12,
    parameter int RSD     = 4,
    parameter int LD      = 2,
    parameter int CW      = 7,
    parameter int IRQ_VEC = DEF_IRQ_VEC
) (
    input  logic                     rst,
    input  logic                     clk,
    input  logic                     cen,
    input  logic                     goto_ja,
    input  logic                     call_ja,
    input  logic                     goto_pt,
    input  logic                     call_pt,
    input  logic                     ret,
    input  logic                     iret,
    input  logic                     pc_halt,
    input  logic                     do_start,
    input  logic [3:0]               do_len,
    input  logic [CW-1:0]            do_cnt,
    input  logic [JW-1:0]            i_field,
    input  logic                     load_pt,
    input  logic [AW-1:0]            load_data,
    input  logic                     ext_irq,
    input  logic                     no_int,
    output logic                     iack,
    output logic [AW-1:0]            rom_addr,
    output logic [AW-1:0]            pt_dout,
    output logic [$clog2(RSD+1)-1:0] stk_lvl,
    output logic                     stk_ovf,
    output logic                     stk_unf,
    output logic                     loop_err,
    output logic                     in_irq
);
    localparam int LEW = loop_w(AW, CW);
    localparam logic [AW-1:0] JM = {AW{1'b1}} >> (AW - JW);

    flow_op_e                 op;
    logic [AW-1:0]            pc, pt, pi, pc1, jt, nxt, seq, rtop, head, lend, dend;
    logic [CW-1:0]            left, cnt;
    logic [LEW-1:0]           ltop;
    logic [$clog2(LD+1)-1:0]  llvl;
    logic rfull, rempty, lfull, lempty, hit, last, irq, lbad, lpush, call;

    always_comb begin
        {head, lend, left} = ltop;
        op    = goto_ja || call_ja ? OP_JA : goto_pt || call_pt ? OP_PT :
                ret ? OP_RET : iret ? OP_IRET : do_start ? OP_DO : OP_SEQ;
        call  = call_ja || call_pt;
        pc1   = pc + 1'b1;
        jt    = (pc & ~JM) | AW'(i_field);
        cnt   = do_cnt == '0 ? CW'(1) : do_cnt;
        dend  = pc + AW'(do_len);
        hit   = !lempty && pc == lend && !pc_halt;
        last  = left <= CW'(1);
        lbad  = lfull || (!lempty && dend >= lend);
        lpush = op == OP_DO && !pc_halt && !lbad;
        // The loop-end check only replaces the sequential default; explicit jumps win.
        seq   = pc_halt ? pc : hit && !last ? head : pc1;
        nxt   = op == OP_JA   ? jt :
                op == OP_PT   ? pt :
                op == OP_RET  ? (rempty ? pc1 : rtop) :
                op == OP_IRET ? pi :
                op == OP_DO   ? (pc_halt ? pc : pc1) : seq;
        irq   = ext_irq && !in_irq && !pc_halt && !no_int && llvl == '0 && op == OP_SEQ;
    end

    jtdsp16_lifo #(.W(AW), .D(RSD), .OVW(1'b1)) u_rstk (
        .rst(rst), .clk(clk), .cen(cen),
        .push(call), .pop(op == OP_RET), .upd(1'b0),
        .din(pc1), .upd_data('0),
        .dout(rtop), .lvl(stk_lvl), .full(rfull), .empty(rempty)
    );

    jtdsp16_lifo #(.W(LEW), .D(LD), .OVW(1'b0)) u_lstk (
        .rst(rst), .clk(clk), .cen(cen),
        .push(lpush), .pop(op == OP_SEQ && hit && last), .upd(op == OP_SEQ && hit && !last),
        .din({pc1, dend, cnt}), .upd_data({head, lend, left - 1'b1}),
        .dout(ltop), .lvl(llvl), .full(lfull), .empty(lempty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= '0;
            pt       <= '0;
            pi       <= '0;
            in_irq   <= 1'b0;
            iack     <= 1'b0;
            stk_ovf  <= 1'b0;
            stk_unf  <= 1'b0;
            loop_err <= 1'b0;
        end else if (cen) begin
            pc       <= irq ? AW'(IRQ_VEC) : nxt;
            pi       <= irq ? nxt : pi;
            pt       <= load_pt ? load_data : pt;
            in_irq   <= irq || (in_irq && op != OP_IRET);
            iack     <= irq;
            stk_ovf  <= stk_ovf || (call && rfull);
            stk_unf  <= stk_unf || (op == OP_RET && rempty);
            loop_err <= loop_err || (op == OP_DO && !pc_halt && lbad);
        end
    end

    assign rom_addr = pc;
    assign pt_dout  = pt;
endmodule

// File: tb/tb_jtdsp16_pcu.sv
// tb_jtdsp16_pcu: directed scoreboard bench for the program control unit.
module tb_jtdsp16_pcu;
    logic        rst = 1'b0, clk = 1'b0, cen;
    logic        goto_ja, call_ja, goto_pt, call_pt, ret, iret, pc_halt, do_start;
    logic [3:0]  do_len;
    logic [6:0]  do_cnt;
    logic [11:0] i_field;
    logic        load_pt, ext_irq, no_int;
    logic [15:0] load_data;
    logic        iack, stk_ovf, stk_unf, loop_err, in_irq;
    logic [15:0] rom_addr, pt_dout;
    logic [2:0]  stk_lvl;

    int          checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    jtdsp16_pcu dut (
        .rst(rst), .clk(clk), .cen(cen),
        .goto_ja(goto_ja), .call_ja(call_ja), .goto_pt(goto_pt), .call_pt(call_pt),
        .ret(ret), .iret(iret), .pc_halt(pc_halt), .do_start(do_start),
        .do_len(do_len), .do_cnt(do_cnt), .i_field(i_field),
        .load_pt(load_pt), .load_data(load_data), .ext_irq(ext_irq), .no_int(no_int),
        .iack(iack), .rom_addr(rom_addr), .pt_dout(pt_dout), .stk_lvl(stk_lvl),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf), .loop_err(loop_err), .in_irq(in_irq)
    );

    always #5 clk = ~clk;

    task automatic clr();
        cen = 1'b1; goto_ja = 1'b0; call_ja = 1'b0; goto_pt = 1'b0; call_pt = 1'b0;
        ret = 1'b0; iret = 1'b0; pc_halt = 1'b0; do_start = 1'b0; do_len = '0;
        do_cnt = '0; i_field = '0; load_pt = 1'b0; load_data = '0; ext_irq = 1'b0; no_int = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [15:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        chk(tag_q.pop_front(), {16'h0, rom_addr}, {16'h0, exp_q.pop_front()});
        clr();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, rom_addr, 0);
        chk({tag, "_pt"}, pt_dout, 0);
        chk({tag, "_lvl"}, stk_lvl, 0);
        chk({tag, "_flags"}, {stk_ovf, stk_unf, loop_err, iack, in_irq}, 0);
    endtask

    task automatic do_loop(input logic [3:0] len, input logic [6:0] n, input logic [15:0] e, input string tag);
        do_start = 1'b1; do_len = len; do_cnt = n;
        step(e, tag);
    endtask

    task automatic jump_pt(input logic [15:0] a, input logic [15:0] after_load);
        load_pt = 1'b1; load_data = a;
        step(after_load, "ldpt");
        goto_pt = 1'b1;
        step(a, "goto_pt");
    endtask

    initial begin
        clr();
        #1 rst = 1'b1;
        #2 chk_reset("reset");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        for (int i = 1; i <= 4; i++) step(16'(i), "free");
        pc_halt = 1'b1; step(16'h4, "halt1");
        pc_halt = 1'b1; step(16'h4, "halt2");
        step(16'h5, "unhalt");
        cen = 1'b0; step(16'h5, "cen_hold");
        load_pt = 1'b1; load_data = 16'h1234; step(16'h6, "ldpt");
        chk("pt_rd", pt_dout, 16'h1234);
        goto_pt = 1'b1; step(16'h1234, "goto_pt");
        call_ja = 1'b1; i_field = 12'h050; step(16'h1050, "call_ja");
        chk("lvl_call", stk_lvl, 1);
        ret = 1'b1; step(16'h1235, "ret");
        chk("lvl_ret", stk_lvl, 0);
        for (int i = 0; i < 5; i++) begin
            call_ja = 1'b1; i_field = 12'h100; step(16'h1100, "call5");
            chk("lvl_fill", stk_lvl, i < 4 ? i + 1 : 4);
        end
        chk("ovf", {stk_ovf, stk_unf}, 2'b10);
        for (int i = 0; i < 4; i++) begin
            ret = 1'b1; step(16'h1101, "ret4");
        end
        ret = 1'b1; step(16'h1102, "ret_empty");
        chk("unf", {stk_unf, stk_lvl}, 4'b1000);
        load_pt = 1'b1; load_data = 16'h0010; goto_pt = 1'b1; step(16'h1234, "pt_old");
        chk("pt_new", pt_dout, 16'h0010);
        goto_pt = 1'b1; step(16'h0010, "goto_pt");
        do_loop(4'd2, 7'd3, 16'h11, "do1");
        step(16'h12, "do1"); step(16'h11, "do1"); step(16'h12, "do1");
        step(16'h11, "do1"); step(16'h12, "do1"); step(16'h13, "do1");
        jump_pt(16'h0020, 16'h0014);
        do_loop(4'd4, 7'd2, 16'h21, "outer");
        do_loop(4'd1, 7'd2, 16'h22, "inner");
        step(16'h22, "nest"); step(16'h23, "nest"); step(16'h24, "nest"); step(16'h21, "nest");
        do_loop(4'd1, 7'd2, 16'h22, "inner2");
        step(16'h22, "nest"); step(16'h23, "nest"); step(16'h24, "nest"); step(16'h25, "nest");
        chk("no_lerr", loop_err, 0);
        jump_pt(16'h0040, 16'h0026);
        ext_irq = 1'b1; step(16'h0001, "irq_vec");
        chk("irq_ack", {iack, in_irq}, 2'b11);
        ext_irq = 1'b1; step(16'h0002, "in_srv");
        chk("ack_once", {iack, in_irq}, 2'b01);
        iret = 1'b1; step(16'h0041, "iret");
        chk("iret_st", in_irq, 0);
        ext_irq = 1'b1; no_int = 1'b1; step(16'h0042, "no_int");
        chk("no_int_ack", iack, 0);
        jump_pt(16'h0060, 16'h0043);
        do_loop(4'd10, 7'd1, 16'h61, "l1");
        do_loop(4'd5, 7'd1, 16'h62, "l2");
        chk("lerr_pre", loop_err, 0);
        do_loop(4'd1, 7'd3, 16'h63, "l3_full");
        chk("lerr_full", loop_err, 1);
        for (int a = 16'h64; a <= 16'h6B; a++) begin
            ext_irq = 1'b1; step(16'(a), "irq_defer");
            chk("defer_ack", iack, 0);
        end
        ext_irq = 1'b1; step(16'h0001, "irq_late");
        chk("late_ack", iack, 1);
        iret = 1'b1; step(16'h006C, "iret2");
        do_loop(4'd3, 7'd5, 16'h6D, "lp_rst");
        call_ja = 1'b1; i_field = 12'h100; step(16'h0100, "call_in_lp");
        chk("lvl_pre_rst", stk_lvl, 1);
        rst = 1'b1;
        #2 chk_reset("midrst");
        @(posedge clk); #1 rst = 1'b0;
        step(16'h1, "resume"); step(16'h2, "resume");
        do_loop(4'd3, 7'd1, 16'h3, "nbad_outer");
        do_loop(4'd4, 7'd1, 16'h4, "nbad_inner");
        chk("lerr_nest", loop_err, 1);
        step(16'h5, "nbad"); step(16'h6, "nbad_pop");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtdsp16_pcu.md
Name: jtdsp16_pcu

Overview:
Parametrised program control unit, the next generation of the XAAU program-sequencing logic. It generates the ROM fetch address, jumps and calls, interrupt entry and return, and zero-overhead DO loops. New features:
- hardware return stack, depth RSD, replacing the single PR register;
- nested DO loops, depth LD;
- configurable address, jump-field and loop-count widths.
Sits between the instruction decoder and program ROM; the table pointer PT lives here.

Parameters:
AW, 16, PC/ROM address width (>= JW)
JW, 12, width of the direct-jump field; high PC bits are preserved on goto/call
RSD, 4, return-stack entries (power of 2, >= 2)
LD, 2, DO-loop nesting depth (>= 1)
CW, 7, loop repeat-count width
IRQ_VEC, 1, interrupt vector address

Ports:
rst  in  1  async reset, active high
clk  in  1  clock
cen  in  1  clock enable; all state advances only when cen=1
goto_ja  in  1  direct jump
call_ja  in  1  direct call
goto_pt  in  1  jump to PT
call_pt  in  1  call to PT
ret  in  1  return from return stack
iret  in  1  return from interrupt
pc_halt  in  1  hold PC (multi-cycle instruction)
do_start  in  1  begin DO loop
do_len  in  4  loop body length in instructions, 1..15
do_cnt  in  CW  repeat count
i_field  in  JW  jump target field
load_pt  in  1  load PT from load_data
load_data  in  AW  PT load value
ext_irq  in  1  interrupt request, level
no_int  in  1  interrupt-inhibit slot
iack  out  1  one-cycle interrupt acknowledge
rom_addr  out  AW  equals PC
pt_dout  out  AW  PT readback
stk_lvl  out  $clog2(RSD+1)  return-stack occupancy
stk_ovf  out  1  sticky: push while full
stk_unf  out  1  sticky: ret while empty
loop_err  out  1  sticky: loop push while full, or illegal nesting
in_irq  out  1  interrupt service active

Behaviour:
- Reset values: PC=0, PT=0, PI=0, stacks empty, stk_lvl=0, all flags 0, iack=0, in_irq=0.
- Decoder guarantee: at most one of goto_ja, call_ja, goto_pt, call_pt, ret, iret, do_start is high per cen cycle.
- Sequential default: PC <= pc_halt ? PC : PC+1. All arithmetic wraps modulo 2^AW.
- goto_ja / call_ja target: {PC[AW-1:JW], i_field}.
- goto_pt / call_pt target: PT.
- Calls push PC+1. When the stack is full, the oldest entry is overwritten (circular), stk_lvl stays RSD, and stk_ovf is set.
- ret pops into PC. When empty, PC <= PC+1, stk_unf is set, and stk_lvl stays 0.
- load_pt: PT <= load_data next cycle. It may coincide with a jump; the jump uses the old PT.
- Interrupt entry condition: ext_irq && !in_irq && !pc_halt && !no_int && loop depth==0 && no flow-change input active. Entry actions:
  - PC <= IRQ_VEC;
  - PI <= the address that would otherwise have been loaded into PC;
  - in_irq <= 1;
  - iack=1 for exactly one cen cycle.
- iret: PC <= PI, in_irq <= 0. iret outside an interrupt behaves as PC <= PI and sets no flag.
- DO loop, with do_start issued at address A:
  - push {head=A+1, end=A+do_len, left=do_cnt}; PC <= A+1 (a halted do_start has no effect);
  - do_cnt=0 behaves as 1.
- Loop end check, applied when PC == end of top entry and !pc_halt:
  - if left>1: left <= left-1, PC <= head;
  - else: pop, PC <= PC+1.
  - The loop check overrides the sequential default only; explicit jumps inside a body take priority and leave the entry intact.
- Nesting rule: an inner loop's end must be strictly less than the current top's end. Otherwise loop_err is set and the loop is not pushed; the body runs once.
- Push when LD entries are active: loop_err is set and the loop is not pushed.
- Sticky flags clear only on reset.
- Latency: every control input takes effect on rom_addr in the next cen cycle. No combinational path from inputs to rom_addr.

Decomposition:
- Shared package jtdsp16_pkg: flow-op encoding constants, the loop-entry field layout (head/end/left widths derived from AW, CW), and the default IRQ_VEC.
- One sub-module, jtdsp16_lifo: generic parametrised stack (width, depth, circular-overwrite option, level, full, empty).
  - Instance 1: return stack, overwrite enabled.
  - Instance 2: loop stack, overwrite disabled, with top-of-stack in-place update for the left counter.

Test Plan:
- Reset, then 5 free cycles -> rom_addr 0,1,2,3,4. With pc_halt at PC=4 for 2 cycles -> 4,4,4,5.
- PC=0x1234, call_ja i_field=0x050 -> PC=0x1050, stk_lvl=1. ret -> PC=0x1235. Five calls with RSD=4 -> stk_ovf=1, then five rets -> fifth sets stk_unf.
- do_start at A=0x10, do_len=2, do_cnt=3 -> rom_addr 11,12,11,12,11,12,13.
- Outer do_start at 0x20 (len 4, cnt 2) with inner at 0x21 (len 1, cnt 2) -> 21,22,22,23,24,21,22,22,23,24,25. A third nested push with LD=2 -> loop_err=1.
- ext_irq at PC=0x40 with no loop active -> next PC=IRQ_VEC, iack high for one cycle, PI=0x41. iret -> PC=0x41, in_irq=0. ext_irq inside a loop -> deferred until the loop pops.
- rst asserted mid-loop with stacks non-empty -> all outputs return to reset values immediately, and PC resumes at 0 after release.
